// File: rtl/async_fifo_pkg.sv
// Pointer helpers shared by the write-side and read-side halves of the async FIFO.
// Pointers are one bit wider than the address so that full and empty can be told apart.
package async_fifo_pkg;

    localparam int MAX_ADDR_WIDTH = 16;
    localparam int MAX_PTR_WIDTH  = MAX_ADDR_WIDTH + 1;

    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    // Full when the write Gray pointer equals the read Gray pointer with its two MSBs inverted.
    function automatic logic ptr_full(
        input logic [MAX_PTR_WIDTH-1:0] wgray,
        input logic [MAX_PTR_WIDTH-1:0] rgray,
        input int                       addr_width
    );
        logic [MAX_PTR_WIDTH-1:0] mask;
        logic [MAX_PTR_WIDTH-1:0] flip;
        mask = (MAX_PTR_WIDTH'(1) << ptr_width(addr_width)) - MAX_PTR_WIDTH'(1);
        flip = MAX_PTR_WIDTH'(3) << (addr_width - 1);
        return ((wgray ^ rgray ^ flip) & mask) == '0;
    endfunction

    function automatic logic ptr_empty(
        input logic [MAX_PTR_WIDTH-1:0] rgray,
        input logic [MAX_PTR_WIDTH-1:0] wgray,
        input int                       addr_width
    );
        logic [MAX_PTR_WIDTH-1:0] mask;
        mask = (MAX_PTR_WIDTH'(1) << ptr_width(addr_width)) - MAX_PTR_WIDTH'(1);
        return ((rgray ^ wgray) & mask) == '0;
    endfunction

endpackage

// File: rtl/binary_to_gray.sv
// Purely combinational binary to reflected-Gray converter.
module binary_to_gray #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] gray_o
);

    assign gray_o[WIDTH-1] = bin_i[WIDTH-1];

    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_bit
        assign gray_o[gi] = bin_i[gi] ^ bin_i[gi+1];
    end

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and full-flag controller of an asynchronous FIFO.
// Full and overflow are registered; wr_accept is the combinational memory write strobe.
module wptr_full_ctrl
    import async_fifo_pkg::*;
#(
    parameter  int ADDR_WIDTH = 4,
    localparam int PTR_W      = ptr_width(ADDR_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [PTR_W-1:0]      rd_gray_sync,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [PTR_W-1:0]      wr_gray,
    output logic                  wr_accept,
    output logic                  full,
    output logic                  overflow
);

    logic [PTR_W-1:0] wbin_q;
    logic [PTR_W-1:0] wbin_d;
    logic [PTR_W-1:0] wgray_q;
    logic [PTR_W-1:0] wgray_d;
    logic             full_q;
    logic             full_d;
    logic             overflow_q;
    logic             overflow_d;

    assign wr_accept  = wr_en & ~full_q;
    assign wbin_d     = wbin_q + PTR_W'(wr_accept);
    assign overflow_d = wr_en & full_q;

    binary_to_gray #(
        .WIDTH (PTR_W)
    ) u_binary_to_gray (
        .bin_i  (wbin_d),
        .gray_o (wgray_d)
    );

    // Evaluated from the post-write pointer and the current read pointer together.
    assign full_d = ptr_full(MAX_PTR_WIDTH'(wgray_d), MAX_PTR_WIDTH'(rd_gray_sync), ADDR_WIDTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            wbin_q     <= '0;
            wgray_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wbin_q     <= wbin_d;
            wgray_q    <= wgray_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    assign wr_addr  = wbin_q[ADDR_WIDTH-1:0];
    assign wr_gray  = wgray_q;
    assign full     = full_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Self-checking bench for wptr_full_ctrl (ADDR_WIDTH=4): directed table, corner sequences, random run.
module tb_wptr_full_ctrl;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int PMOD  = 2 * DEPTH;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW:0]   rd_gray_sync = '0;
    logic [AW-1:0] wr_addr;
    logic [AW:0]   wr_gray;
    logic          wr_accept;
    logic          full;
    logic          overflow;

    wptr_full_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .rd_gray_sync (rd_gray_sync),
        .wr_addr      (wr_addr),
        .wr_gray      (wr_gray),
        .wr_accept    (wr_accept),
        .full         (full),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: write count and occupancy as plain integers.
    int   m_w      = 0;
    logic m_full   = 1'b0;
    logic m_ovf    = 1'b0;
    logic model_ok = 1'b0;

    logic        acc_s;
    logic [AW-1:0] addr_pre;

    function automatic logic [AW:0] gray_of(input int b);
        logic [AW:0] x;
        x = b[AW:0];
        return x ^ (x >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic we, input int rb);
        logic ea;
        @(negedge clk);
        rst          = r;
        wr_en        = we;
        rd_gray_sync = gray_of(rb);
        #1;
        acc_s    = wr_accept;
        addr_pre = wr_addr;
        if (model_ok) begin
            ea = we & ~m_full;
            chk("model_accept", 32'(acc_s), 32'(ea));
        end
        if (r) begin
            m_w    = 0;
            m_full = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            m_ovf  = we && m_full;
            if (we && !m_full) m_w = (m_w + 1) % PMOD;
            m_full = (((m_w - rb) % PMOD + PMOD) % PMOD) == DEPTH;
        end
        @(posedge clk);
        #1;
        if (r) model_ok = 1'b1;
        if (model_ok) begin
            chk("model_addr", 32'(wr_addr), 32'(m_w % DEPTH));
            chk("model_gray", 32'(wr_gray), 32'(gray_of(m_w)));
            chk("model_full", 32'(full), 32'(m_full));
            chk("model_ovf",  32'(overflow), 32'(m_ovf));
        end
        $display("cyc rst=%0b wr_en=%0b rd_bin=%0d acc=%0b addr=%0d gray=%05b full=%0b ovf=%0b",
                 r, we, rb, acc_s, wr_addr, wr_gray, full, overflow);
    endtask

    typedef struct {
        logic r;
        logic we;
        int   rb;
        logic chk_acc;
        logic acc;
        int   addr;
        int   gray;
        logic full;
        logic ovf;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl [NV];

    initial begin
        int rb;
        int occ;
        int wp;

        // Reset with wr_en high, fill 16, overflow 3, drain one, refill one.
        tbl[0] = '{1'b1, 1'b1, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 0, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0};
        for (int i = 0; i < DEPTH; i++)
            tbl[2+i] = '{1'b0, 1'b1, 0, 1'b1, 1'b1, (i + 1) % DEPTH,
                         int'(gray_of(i + 1)), (i == DEPTH - 1), 1'b0};
        for (int i = 0; i < 3; i++)
            tbl[18+i] = '{1'b0, 1'b1, 0, 1'b1, 1'b0, 0, 5'b11000, 1'b1, 1'b1};
        tbl[21] = '{1'b0, 1'b0, 1, 1'b1, 1'b0, 0, 5'b11000, 1'b0, 1'b0};
        tbl[22] = '{1'b0, 1'b1, 1, 1'b1, 1'b1, 1, 5'b11001, 1'b1, 1'b0};

        for (int i = 0; i < NV; i++) begin
            cyc(tbl[i].r, tbl[i].we, tbl[i].rb);
            if (tbl[i].chk_acc) chk("tbl_accept", 32'(acc_s), 32'(tbl[i].acc));
            chk("tbl_addr", 32'(wr_addr), 32'(tbl[i].addr));
            chk("tbl_gray", 32'(wr_gray), 32'(tbl[i].gray));
            chk("tbl_full", 32'(full), 32'(tbl[i].full));
            chk("tbl_ovf",  32'(overflow), 32'(tbl[i].ovf));
        end

        // Wrap: 40 writes with the read pointer two entries behind.
        cyc(1'b1, 1'b0, 0);
        wp = 0;
        for (int k = 1; k <= 40; k++) begin
            rb = (wp >= 2) ? wp - 2 : 0;
            cyc(1'b0, 1'b1, rb % PMOD);
            wp = k;
            chk("wrap_full_never", 32'(full), 32'(0));
            if (k == 31) begin
                chk("wrap_gray_31", 32'(wr_gray), 32'(5'b10000));
                chk("wrap_addr_31", 32'(wr_addr), 32'(15));
            end
            if (k == 32) begin
                chk("wrap_gray_32", 32'(wr_gray), 32'(5'b00000));
                chk("wrap_addr_32", 32'(wr_addr), 32'(0));
            end
        end

        // Mid-stream reset after 7 writes; the write in the reset cycle is lost.
        cyc(1'b1, 1'b0, 0);
        for (int k = 0; k < 7; k++) cyc(1'b0, 1'b1, 0);
        chk("mid_addr_before", 32'(wr_addr), 32'(7));
        cyc(1'b1, 1'b1, 0);
        chk("mid_rst_accept", 32'(acc_s), 32'(1));
        chk("mid_rst_addr", 32'(wr_addr), 32'(0));
        chk("mid_rst_gray", 32'(wr_gray), 32'(0));
        chk("mid_rst_full", 32'(full), 32'(0));
        cyc(1'b0, 1'b1, 0);
        chk("mid_next_addr_used", 32'(addr_pre), 32'(0));
        chk("mid_next_addr_after", 32'(wr_addr), 32'(1));

        // Random traffic with bursty write/read rates so full is reached and left.
        cyc(1'b1, 1'b0, 0);
        rb = 0;
        for (int n = 0; n < 600; n++) begin
            logic r;
            logic we;
            int   wprob;
            int   rprob;
            wprob = ((n / 60) % 2 == 0) ? 90 : 30;
            rprob = ((n / 60) % 2 == 0) ? 25 : 80;
            r  = ($urandom_range(99, 0) < 2);
            we = ($urandom_range(99, 0) < wprob);
            occ = ((m_w - rb) % PMOD + PMOD) % PMOD;
            if (occ > 0 && $urandom_range(99, 0) < rprob) rb = (rb + 1) % PMOD;
            cyc(r, we, rb);
            if (r) rb = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
